multicycle_ctrl: RTL

//  Multi-cycle sequencer for the MIPS32 datapath: replaces the single-cycle Control/ALUctrl pairing when

---
 rtl/multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS32 sequencer: walks FETCH/DECODE/EXEC/MEM/WB and drives datapath enables and selects.
// Latency: lw 5, sw/R-type/addi 4, beq/j/jr 3 cycles when mem_ready returns immediately.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready; MEM_TIMEOUT stalled cycles -> fault and HALT.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_re,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_srca,
  output logic [1:0]       alu_srcb,
  output logic [3:0]       alu_code,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic [1:0]       fault
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4,
    S_MEM_WR = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALU_WB = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JR     = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [1:0] F_NONE    = 2'b00;
  localparam logic [1:0] F_ILLEGAL = 2'b01;
  localparam logic [1:0] F_TIMEOUT = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;

  // Counter holds up to MEM_TIMEOUT (it increments on the faulting cycle too).
  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            cur;
  state_t            nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_cnt;
  logic [1:0]        fault_reg;
  logic [1:0]        fault_set;
  logic              retire;
  logic              stall;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign state        = cur;
  assign retired      = retired_cnt;
  assign fault        = fault_reg;

  // Next-state, retire/fault events and all datapath controls; everything is held at rest during reset.
  always_comb begin
    nxt        = cur;
    fault_set  = F_NONE;
    retire     = 1'b0;
    stall      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_srca   = 1'b0;
    alu_srcb   = 2'b00;
    alu_code   = ALU_ADD;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          mem_re   = 1'b1;
          alu_srcb = 2'b01;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            nxt   = S_DECODE;
          end else begin
            stall = 1'b1;
            if (wait_expired) begin
              fault_set = F_TIMEOUT;
              nxt       = S_HALT;
            end
          end
        end
        S_DECODE: begin
          // ALU precomputes the branch target while the opcode is decoded.
          alu_srcb = 2'b11;
          case (opcode)
            6'h00: begin
              case (funct)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: nxt = S_EXEC_R;
                6'h08:                             nxt = S_JR;
                default: begin
                  fault_set = F_ILLEGAL;
                  nxt       = S_HALT;
                end
              endcase
            end
            6'h23, 6'h2B: nxt = S_ADDR;
            6'h04:        nxt = S_BRANCH;
            6'h08:        nxt = S_EXEC_I;
            6'h02:        nxt = S_JUMP;
            default: begin
              fault_set = F_ILLEGAL;
              nxt       = S_HALT;
            end
          endcase
        end
        S_ADDR: begin
          alu_srca = 1'b1;
          alu_srcb = 2'b10;
          nxt      = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_re = 1'b1;
          iord   = 1'b1;
          if (mem_ready) begin
            nxt = S_MEM_WB;
          end else begin
            stall = 1'b1;
            if (wait_expired) begin
              fault_set = F_TIMEOUT;
              nxt       = S_HALT;
            end
          end
        end
        S_MEM_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          nxt        = S_FETCH;
        end
        S_MEM_WR: begin
          mem_we = 1'b1;
          iord   = 1'b1;
          if (mem_ready) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            stall = 1'b1;
            if (wait_expired) begin
              fault_set = F_TIMEOUT;
              nxt       = S_HALT;
            end
          end
        end
        S_EXEC_R: begin
          alu_srca = 1'b1;
          case (funct)
            6'h22:   alu_code = ALU_SUB;
            6'h24:   alu_code = ALU_AND;
            6'h25:   alu_code = ALU_OR;
            6'h2A:   alu_code = ALU_SLT;
            default: alu_code = ALU_ADD;
          endcase
          nxt = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_srca = 1'b1;
          alu_srcb = 2'b10;
          nxt      = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_we  = 1'b1;
          reg_dst = (opcode == 6'h00);
          retire  = 1'b1;
          nxt     = S_FETCH;
        end
        S_BRANCH: begin
          alu_srca = 1'b1;
          alu_code = ALU_SUB;
          pc_we    = zero;
          pc_src   = 2'b01;
          retire   = 1'b1;
          nxt      = S_FETCH;
        end
        S_JUMP: begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
          retire = 1'b1;
          nxt    = S_FETCH;
        end
        S_JR: begin
          pc_we  = 1'b1;
          pc_src = 2'b11;
          retire = 1'b1;
          nxt    = S_FETCH;
        end
        S_HALT: nxt = S_HALT;
        default: nxt = S_HALT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Stall counter: counts consecutive stalled cycles, cleared by any non-stall cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      wait_cnt <= '0;
    else if (stall) wait_cnt <= wait_cnt + 1'b1;
    else            wait_cnt <= '0;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + 1'b1;
  end

  // Sticky fault code; only ever written on the transition into HALT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   fault_reg <= F_NONE;
    else if (fault_set != F_NONE) fault_reg <= fault_set;
  end

endmodule
